uart_io_ctrl: RTL and testbench
===============================

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and writeback data width; SHALL be a multiple of 8 and at least 32.
REQ-002 clk  in  1  single clock, rising edge; all state SHALL change only on this edge.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 UARTtoReg  in  1  EX-stage instruction reads UART into a register.
REQ-005 RegtoUART  in  1  EX-stage instruction writes register data to UART.
REQ-006 register_data  in  DATA_WIDTH  source operand for RegtoUART.
REQ-007 rdist  in  5  destination register for UARTtoReg.
REQ-008 flush  in  1  pipeline flush; aborts the transfer in progress.
REQ-009 rx_valid / rx_data  in  1 / 8  receiver byte available / byte value.
REQ-010 rx_ready  out  1  byte accepted when rx_valid && rx_ready.
REQ-011 tx_valid / tx_byte  out  1 / 8  transmit request / byte value.
REQ-012 tx_ready  in  1  byte taken when tx_valid && tx_ready.
REQ-013 stall  out  1  freezes the IF/ID/EX pipeline registers.
REQ-014 wb_valid / wb_rdist / wb_data  out  1 / 5 / DATA_WIDTH  register writeback of received data.

Function
REQ-015 FSM states: IDLE, RX, TX, DONE; a 2-bit byte counter cnt; NB = 4 when word mode is compiled in (REQ-029), otherwise NB = 1.
REQ-016 IDLE: UARTtoReg=1 SHALL latch rdist, clear cnt and go to RX; RegtoUART=1 SHALL latch register_data, clear cnt and go to TX.
REQ-017 Simultaneous UARTtoReg and RegtoUART in IDLE: UARTtoReg SHALL win and RegtoUART SHALL be ignored.
REQ-018 stall SHALL be combinational, =1 in IDLE while a request is present, and =1 throughout RX and TX.
REQ-019 stall SHALL be 0 in DONE; requests seen in DONE SHALL be ignored, and DONE SHALL always go to IDLE next cycle.
REQ-020 RX: rx_ready=1; each handshake stores rx_data into byte cnt of the shift register (byte 0 = LSB, little-endian).
REQ-021 RX: cnt SHALL increment on every handshake; the handshake with cnt==NB-1 SHALL go to DONE.
REQ-022 DONE after RX: wb_valid=1 for exactly one cycle, with wb_rdist = latched rdist and wb_data = assembled bytes zero-extended to DATA_WIDTH.
REQ-023 TX: tx_valid=1 and tx_byte = latched data byte cnt; each tx_ready SHALL increment cnt; the handshake with cnt==NB-1 SHALL go to DONE; wb_valid SHALL stay 0.
REQ-024 tx_byte SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-025 flush=1 in any state SHALL go to IDLE next cycle with no wb_valid; a handshake in the same cycle SHALL still complete on the UART side, but its data SHALL be discarded.
REQ-026 Minimum latency: request cycle plus NB handshake cycles plus the DONE cycle; total stall cycles SHALL be 1 + NB when the UART is always ready.

Reset
REQ-027 rstn=0 SHALL immediately force IDLE and cnt=0, and clear the latched data and rdist.
REQ-028 During reset, rx_ready, tx_valid, tx_byte, stall, wb_valid, wb_rdist and wb_data SHALL all be 0; reset mid-transfer SHALL drop the transfer silently.

Configuration
REQ-029 Macro UART_IO_WORD_EN: when defined, NB=4 (full 32-bit word moved LSB-first); when undefined, NB=1 (single byte, wb_data = {zeros, rx_data}, tx_byte = register_data[7:0]).

Structure
REQ-030 Shared package uart_io_pkg SHALL hold the state enum type and the NB constant (selected by UART_IO_WORD_EN).
REQ-031 The block SHALL be one module with no sub-module; the FSM, counter and shift register SHALL live in uart_io_ctrl.

Verification
REQ-032 Byte mode: UARTtoReg, rdist=5, rx_valid after 3 cycles with rx_data=0x41 -> stall high 4 cycles, then wb_valid one cycle, wb_rdist=5, wb_data=0x00000041.
REQ-033 Byte mode: RegtoUART, register_data=0x12345678, tx_ready=1 -> tx_byte=0x78 for one cycle, stall=1 for 2 cycles, no wb_valid.
REQ-034 Word mode: UARTtoReg, bytes 0xEF,0xBE,0xAD,0xDE -> wb_data=0xDEADBEEF; TX of 0xDEADBEEF with tx_ready toggling -> tx_byte sequence 0xEF,0xBE,0xAD,0xDE, each held stable while stalled.
REQ-035 UARTtoReg and RegtoUART both asserted -> RX path taken, tx_valid never asserted.
REQ-036 Flush in RX after 1 of 4 bytes -> IDLE next cycle, no wb_valid; a following UARTtoReg assembles a fresh word from cnt=0.
REQ-037 rstn pulled low mid-TX -> tx_valid and stall go to 0 at once; after release the FSM is in IDLE and accepts a new request.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared types and byte-count constant for the UART register-transfer controller.
// UART_IO_WORD_EN selects word transfers (4 bytes); otherwise single-byte transfers.
package uart_io_pkg;

  typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_e;

`ifdef UART_IO_WORD_EN
  localparam int NB = 4;
`else
  localparam int NB = 1;
`endif

  localparam logic [1:0] LAST_CNT = 2'(NB - 1);

endpackage

// File: rtl/uart_io_ctrl_if.sv
// UART byte streams plus register writeback, bundled between the controller (master)
// and the UART/regfile side (slave).
interface uart_io_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  tx_valid;
  logic [7:0]            tx_byte;
  logic                  tx_ready;
  logic                  wb_valid;
  logic [4:0]            wb_rdist;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_byte, wb_valid, wb_rdist, wb_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_byte, wb_valid, wb_rdist, wb_data
  );
endinterface

// File: rtl/uart_io_ctrl.sv
// Stalls the pipeline while moving NB bytes between a register and the UART (LSB first).
// Word mode (NB=4) is built when UART_IO_WORD_EN is defined, byte mode otherwise.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  UARTtoReg,
  input  logic                  RegtoUART,
  input  logic [DATA_WIDTH-1:0] register_data,
  input  logic [4:0]            rdist,
  input  logic                  flush,
  output logic                  stall,
  uart_io_ctrl_if.master        io
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [4:0]            rdist_q, rdist_d;
  logic                  is_rx_q, is_rx_d;
  logic                  stall_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      rdist_q <= 5'd0;
      is_rx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdist_q <= rdist_d;
      is_rx_q <= is_rx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rdist_d     = rdist_q;
    is_rx_d     = is_rx_q;
    stall_c     = 1'b0;
    io.rx_ready = 1'b0;
    io.tx_valid = 1'b0;
    io.tx_byte  = 8'd0;
    io.wb_valid = 1'b0;
    io.wb_rdist = 5'd0;
    io.wb_data  = '0;
    case (state_q)
      IDLE: begin
        stall_c = UARTtoReg | RegtoUART;
        if (!flush) begin
          // Receive takes priority when both requests arrive together.
          if (UARTtoReg) begin
            rdist_d = rdist;
            data_d  = '0;
            cnt_d   = 2'd0;
            is_rx_d = 1'b1;
            state_d = RX;
          end else if (RegtoUART) begin
            data_d  = register_data;
            cnt_d   = 2'd0;
            is_rx_d = 1'b0;
            state_d = TX;
          end
        end
      end
      RX: begin
        stall_c     = 1'b1;
        io.rx_ready = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (io.rx_valid) begin
          data_d[{cnt_q, 3'b000} +: 8] = io.rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      TX: begin
        stall_c     = 1'b1;
        io.tx_valid = 1'b1;
        io.tx_byte  = data_q[{cnt_q, 3'b000} +: 8];
        if (flush) begin
          state_d = IDLE;
        end else if (io.tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_rx_q && !flush) begin
          io.wb_valid = 1'b1;
          io.wb_rdist = rdist_q;
          io.wb_data  = data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests may still be asserted while reset holds the FSM in IDLE.
  assign stall = rstn & stall_c;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Randomized transaction bench: per-cycle expectations derived from the transfer rules,
// checked every falling edge, plus literal checks on captured words and byte streams.
module tb_uart_io_ctrl;
  localparam int NB = uart_io_pkg::NB;

  logic        clk = 1'b0;
  logic        rstn;
  logic        UARTtoReg, RegtoUART, flush;
  logic [31:0] register_data;
  logic [4:0]  rdist;
  logic        stall;

  uart_io_ctrl_if #(.DATA_WIDTH(32)) io ();

  uart_io_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
    .register_data(register_data), .rdist(rdist), .flush(flush),
    .stall(stall), .io(io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int stall_cnt = 0;
  logic [7:0]  tx_log[$];
  logic [31:0] last_wb = 32'd0;

  logic        exp_stall, exp_rx_ready, exp_tx_valid, exp_wb_valid;
  logic [7:0]  exp_tx_byte;
  logic [4:0]  exp_wb_rdist;
  logic [31:0] exp_wb_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic s, input logic rr, input logic tv, input logic [7:0] tb,
                         input logic wv, input logic [4:0] wr, input logic [31:0] wd);
    exp_stall = s; exp_rx_ready = rr; exp_tx_valid = tv; exp_tx_byte = tb;
    exp_wb_valid = wv; exp_wb_rdist = wr; exp_wb_data = wd;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("rx_ready", 32'(io.rx_ready), 32'(exp_rx_ready));
      chk("tx_valid", 32'(io.tx_valid), 32'(exp_tx_valid));
      if (exp_tx_valid) chk("tx_byte", 32'(io.tx_byte), 32'(exp_tx_byte));
      chk("wb_valid", 32'(io.wb_valid), 32'(exp_wb_valid));
      if (exp_wb_valid) begin
        chk("wb_rdist", 32'(io.wb_rdist), 32'(exp_wb_rdist));
        chk("wb_data", io.wb_data, exp_wb_data);
      end
      if (!rstn) begin
        chk("rst_tx_byte", 32'(io.tx_byte), 32'd0);
        chk("rst_wb_rdist", 32'(io.wb_rdist), 32'd0);
        chk("rst_wb_data", io.wb_data, 32'd0);
      end
      if (stall === 1'b1) stall_cnt++;
      if (io.tx_valid === 1'b1 && io.tx_ready === 1'b1) tx_log.push_back(io.tx_byte);
      if (io.wb_valid === 1'b1) last_wb = io.wb_data;
    end
  end

  function automatic logic [31:0] nb_mask(input logic [31:0] w);
    return (NB == 4) ? w : {24'h0, w[7:0]};
  endfunction

  // vmode: 0 random valid, 1 always valid, 2 valid from the third RX cycle on.
  task automatic do_rx(input logic [4:0] rd, input logic [31:0] w, input int vmode,
                       input int flush_after, input bit both);
    int got = 0;
    int n = 0;
    @(posedge clk); #1;
    stall_cnt = 0; tx_log.delete();
    UARTtoReg = 1'b1; RegtoUART = both; rdist = rd; register_data = $urandom;
    io.rx_valid = $urandom_range(0, 1); io.rx_data = 8'($urandom);
    set_exp(1, 0, 0, 0, 0, 0, 0);
    while (got < NB) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("rx_timeout", 32'(n), 32'd200);
        break;
      end
      rdist = 5'($urandom); register_data = $urandom;
      case (vmode)
        0: io.rx_valid = ($urandom_range(0, 2) != 0);
        1: io.rx_valid = 1'b1;
        default: io.rx_valid = (n > 2);
      endcase
      io.rx_data = w[8*got +: 8];
      set_exp(1, 1, 0, 0, 0, 0, 0);
      if (got == flush_after) begin
        flush = 1'b1; UARTtoReg = 1'b0; RegtoUART = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; io.rx_valid = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (io.rx_valid) got++;
    end
    @(posedge clk); #1;
    io.rx_valid = $urandom_range(0, 1);
    set_exp(0, 0, 0, 0, 1, rd, nb_mask(w));
    @(posedge clk); #1;
    UARTtoReg = 1'b0; RegtoUART = 1'b0; io.rx_valid = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
  endtask

  // rmode: 0 random ready, 1 always ready, 2 toggling ready.
  task automatic do_tx(input logic [31:0] w, input int rmode, input int flush_after);
    int sent = 0;
    int n = 0;
    @(posedge clk); #1;
    stall_cnt = 0; tx_log.delete();
    RegtoUART = 1'b1; register_data = w; io.tx_ready = $urandom_range(0, 1);
    set_exp(1, 0, 0, 0, 0, 0, 0);
    while (sent < NB) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("tx_timeout", 32'(n), 32'd200);
        break;
      end
      register_data = $urandom;
      case (rmode)
        0: io.tx_ready = $urandom_range(0, 1);
        1: io.tx_ready = 1'b1;
        default: io.tx_ready = n[0];
      endcase
      set_exp(1, 0, 1, w[8*sent +: 8], 0, 0, 0);
      if (sent == flush_after) begin
        flush = 1'b1; RegtoUART = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; io.tx_ready = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (io.tx_ready) sent++;
    end
    @(posedge clk); #1;
    io.tx_ready = $urandom_range(0, 1);
    set_exp(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    RegtoUART = 1'b0; io.tx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] beef [4];
    beef[0] = 8'hEF; beef[1] = 8'hBE; beef[2] = 8'hAD; beef[3] = 8'hDE;

    rstn = 1'b0; UARTtoReg = 1'b1; RegtoUART = 1'b1; flush = 1'b0;
    register_data = 32'hFFFF_FFFF; rdist = 5'h1F;
    io.rx_valid = 1'b1; io.rx_data = 8'hFF; io.tx_ready = 1'b1;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_rx_ready", 32'(io.rx_ready), 32'd0);
    chk("reset_tx_valid", 32'(io.tx_valid), 32'd0);
    chk("reset_tx_byte", 32'(io.tx_byte), 32'd0);
    chk("reset_wb_valid", 32'(io.wb_valid), 32'd0);
    chk("reset_wb_rdist", 32'(io.wb_rdist), 32'd0);
    chk("reset_wb_data", io.wb_data, 32'd0);
    #20;
    @(posedge clk); #1;
    rstn = 1'b1; UARTtoReg = 1'b0; RegtoUART = 1'b0;
    io.rx_valid = 1'b0; io.tx_ready = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // Receive with data arriving on the third RX cycle.
    do_rx(5'd5, (NB == 4) ? 32'h0000_0041 : 32'h41, 2, -1, 0);
    chk("rx_delay_stall_cycles", 32'(stall_cnt), 32'(3 + NB));
    chk("rx_0x41_word", last_wb, 32'h0000_0041);

    // Transmit with an always-ready UART.
    do_tx(32'h1234_5678, 1, -1);
    chk("tx_stall_cycles", 32'(stall_cnt), 32'(1 + NB));
    chk("tx_count", 32'(tx_log.size()), 32'(NB));
    if (tx_log.size() > 0) chk("tx_first_byte", 32'(tx_log[0]), 32'h78);

    do_rx(5'd9, 32'hDEAD_BEEF, 0, -1, 0);
    chk("rx_deadbeef", last_wb, (NB == 4) ? 32'hDEAD_BEEF : 32'h0000_00EF);

    do_tx(32'hDEAD_BEEF, 2, -1);
    chk("tx_beef_count", 32'(tx_log.size()), 32'(NB));
    for (int i = 0; i < NB && i < tx_log.size(); i++)
      chk("tx_beef_byte", 32'(tx_log[i]), 32'(beef[i]));

    // Both requests at once: receive path wins, no transmit.
    do_rx(5'd12, 32'hCAFE_F00D, 1, -1, 1);
    chk("both_no_tx", 32'(tx_log.size()), 32'd0);
    chk("both_rx_word", last_wb, nb_mask(32'hCAFE_F00D));

    // Flush mid-receive, then a fresh receive.
    last_wb = 32'd0;
    do_rx(5'd3, 32'h1111_2222, 1, (NB > 1) ? 1 : 0, 0);
    chk("flush_no_wb", last_wb, 32'd0);
    do_rx(5'd4, 32'hA5C3_7E19, 1, -1, 0);
    chk("after_flush_word", last_wb, nb_mask(32'hA5C3_7E19));
    do_tx(32'h0BAD_F00D, 1, 0);

    // Reset asserted while transmitting.
    @(posedge clk); #1;
    RegtoUART = 1'b1; register_data = 32'h5566_7788; io.tx_ready = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    set_exp(1, 0, 1, 8'h88, 0, 0, 0);
    @(posedge clk); #3;
    rstn = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midtx_rst_tx_valid", 32'(io.tx_valid), 32'd0);
    chk("midtx_rst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; RegtoUART = 1'b0;
    do_tx(32'h99AA_BBCC, 1, -1);
    chk("post_rst_tx_count", 32'(tx_log.size()), 32'(NB));
    if (tx_log.size() > 0) chk("post_rst_tx_byte0", 32'(tx_log[0]), 32'hCC);

    // Randomized mix of transfers.
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 2);
      int md = $urandom_range(0, 2);
      int fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NB - 1) : -1;
      logic [31:0] w = $urandom;
      if (kind == 0) do_tx(w, md, fa);
      else do_rx(5'($urandom), w, md, fa, kind == 2);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
